clause_db_ctrl: RTL and testbench

- Sequencer and arbiter in front of the BCP unit's clause database (variable-indexed clause-occurrence bitmaps, 1-cycle registered read).
- Shares the database between three clients:
  - a loader that writes occurrence rows;
  - a BCP lookup port that reads one variable's row;
  - a scan engine that ORs together the rows of all variables in a mask, giving the set of clauses touched by an assignment batch.
- Owns every database control signal; nothing else drives the database.

---
 rtl/sat_pkg.sv | 11 +
 rtl/clause_db_scan_acc.sv | 38 +++
 rtl/clause_db_ctrl.sv | 121 ++++++++++++
 tb/tb_clause_db_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// sat_pkg: shared sizes, vector typedefs and controller state encoding for the clause database
package sat_pkg;
  localparam int CLAUSE_NUM  = 7;
  localparam int VAR_NUM     = 7;
  localparam int VAR_NUM_LOG = 3;
  typedef logic [CLAUSE_NUM-1:0]  clause_vec_t;
  typedef logic [VAR_NUM_LOG-1:0] var_addr_t;
  typedef logic [VAR_NUM-1:0]     var_mask_t;
  typedef enum logic [2:0] {IDLE, LD_ISSUE, LK_ISSUE, LK_WAIT, LK_CAP, SCAN} ctrl_state_t;
  localparam var_addr_t LAST_ADDR = var_addr_t'(VAR_NUM - 1);
endpackage

// File: rtl/clause_db_scan_acc.sv
// clause_db_scan_acc: delays scan read issues by two stages to line up with db rows, ORs masked rows
//   clk, rst(async, active-low); clear_i zeroes accumulator; v_i/addr_i scan read being issued;
//   mask_i captured variable mask; row_i db read data; done_o last row present; acc_o accumulator incl. current row
module clause_db_scan_acc
  import sat_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   v_i,
  input  logic [VAR_NUM_LOG-1:0] addr_i,
  input  logic [VAR_NUM-1:0]     mask_i,
  input  logic [CLAUSE_NUM-1:0]  row_i,
  output logic                   done_o,
  output logic [CLAUSE_NUM-1:0]  acc_o
);
  logic        v1_q, v2_q;
  var_addr_t   a1_q, a2_q;
  clause_vec_t acc_q;
  // stage 1 matches the cycle the read is on the db bus, stage 2 the cycle its row comes back
  assign acc_o  = acc_q | ((v2_q && mask_i[a2_q]) ? row_i : '0);
  assign done_o = v2_q && a2_q == LAST_ADDR;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      a1_q  <= '0;
      a2_q  <= '0;
      acc_q <= '0;
    end else begin
      v1_q  <= v_i;
      v2_q  <= v1_q;
      a1_q  <= addr_i;
      a2_q  <= a1_q;
      acc_q <= clear_i ? '0 : acc_o;
    end
  end
endmodule

// File: rtl/clause_db_ctrl.sv
// clause_db_ctrl: arbitrates loader / lookup / scan access to the clause occurrence database
//   clk, rst(async, active-low)
//   ld_req/ld_addr/ld_data -> ld_ack        loader row writes
//   lk_req/lk_addr -> lk_ack, lk_valid, lk_data   single-row lookup
//   scan_start/scan_mask -> scan_busy, scan_done, scan_result   OR of masked rows
//   db_en/db_write/db_address/db_in -> database, db_out <- database (registered read)
module clause_db_ctrl
  import sat_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_req,
  input  logic [VAR_NUM_LOG-1:0] ld_addr,
  input  logic [CLAUSE_NUM-1:0]  ld_data,
  output logic                   ld_ack,
  input  logic                   lk_req,
  input  logic [VAR_NUM_LOG-1:0] lk_addr,
  output logic                   lk_ack,
  output logic                   lk_valid,
  output logic [CLAUSE_NUM-1:0]  lk_data,
  input  logic                   scan_start,
  input  logic [VAR_NUM-1:0]     scan_mask,
  output logic                   scan_busy,
  output logic                   scan_done,
  output logic [CLAUSE_NUM-1:0]  scan_result,
  output logic                   db_en,
  output logic                   db_write,
  output logic [VAR_NUM_LOG-1:0] db_address,
  output logic [CLAUSE_NUM-1:0]  db_in,
  input  logic [CLAUSE_NUM-1:0]  db_out
);
  ctrl_state_t state_q, state_d;
  logic        ld_ack_q, ld_ack_d, lk_ack_q, lk_ack_d, lk_valid_q, lk_valid_d;
  logic        scan_done_q, scan_done_d, db_en_q, db_en_d, db_write_q, db_write_d;
  clause_vec_t lk_data_q, lk_data_d, scan_result_q, scan_result_d, db_in_q, db_in_d, acc_next;
  var_addr_t   db_address_q, db_address_d;
  var_mask_t   mask_q, mask_d;
  logic        acc_ld, acc_sc, acc_lk, ld_ok, lk_ok, scan_iss, scan_last;
  always_comb begin
    acc_ld   = state_q == IDLE && ld_req;
    acc_sc   = state_q == IDLE && !ld_req && scan_start;
    acc_lk   = state_q == IDLE && !ld_req && !scan_start && lk_req;
    ld_ok    = acc_ld && ld_addr <= LAST_ADDR;
    lk_ok    = acc_lk && lk_addr <= LAST_ADDR;
    // the registered scan address doubles as the sweep counter; it stops issuing once the last row went out
    scan_iss = acc_sc || (state_q == SCAN && db_en_q && db_address_q != LAST_ADDR);
    state_d  = state_q;
    unique case (state_q)
      IDLE:     state_d = acc_ld ? LD_ISSUE : acc_sc ? SCAN : acc_lk ? LK_ISSUE : IDLE;
      LD_ISSUE: state_d = IDLE;
      LK_ISSUE: state_d = LK_WAIT;
      LK_WAIT:  state_d = LK_CAP;
      LK_CAP:   state_d = IDLE;
      SCAN:     state_d = scan_last ? IDLE : SCAN;
      default:  state_d = IDLE;
    endcase
    ld_ack_d      = acc_ld;
    lk_ack_d      = acc_lk;
    lk_valid_d    = state_q == LK_WAIT;
    lk_data_d     = state_q == LK_WAIT ? db_out : lk_data_q;
    scan_done_d   = scan_last;
    scan_result_d = scan_last ? acc_next : scan_result_q;
    mask_d        = acc_sc ? scan_mask : mask_q;
    db_en_d       = ld_ok || lk_ok || scan_iss;
    db_write_d    = ld_ok;
    db_address_d  = ld_ok ? ld_addr : lk_ok ? lk_addr :
                    (scan_iss && !acc_sc) ? db_address_q + var_addr_t'(1) : '0;
    db_in_d       = ld_ok ? ld_data : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ld_ack_q      <= 1'b0;
      lk_ack_q      <= 1'b0;
      lk_valid_q    <= 1'b0;
      lk_data_q     <= '0;
      scan_done_q   <= 1'b0;
      scan_result_q <= '0;
      mask_q        <= '0;
      db_en_q       <= 1'b0;
      db_write_q    <= 1'b0;
      db_address_q  <= '0;
      db_in_q       <= '0;
    end else begin
      state_q       <= state_d;
      ld_ack_q      <= ld_ack_d;
      lk_ack_q      <= lk_ack_d;
      lk_valid_q    <= lk_valid_d;
      lk_data_q     <= lk_data_d;
      scan_done_q   <= scan_done_d;
      scan_result_q <= scan_result_d;
      mask_q        <= mask_d;
      db_en_q       <= db_en_d;
      db_write_q    <= db_write_d;
      db_address_q  <= db_address_d;
      db_in_q       <= db_in_d;
    end
  end
  clause_db_scan_acc u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear_i (acc_sc),
    .v_i     (scan_iss),
    .addr_i  (db_address_d),
    .mask_i  (mask_q),
    .row_i   (db_out),
    .done_o  (scan_last),
    .acc_o   (acc_next)
  );
  assign ld_ack      = ld_ack_q;
  assign lk_ack      = lk_ack_q;
  assign lk_valid    = lk_valid_q;
  assign lk_data     = lk_data_q;
  assign scan_busy   = state_q == SCAN;
  assign scan_done   = scan_done_q;
  assign scan_result = scan_result_q;
  assign db_en       = db_en_q;
  assign db_write    = db_write_q;
  assign db_address  = db_address_q;
  assign db_in       = db_in_q;
endmodule

// File: tb/tb_clause_db_ctrl.sv
// tb_clause_db_ctrl: directed bench with a database model, a transaction-level reference schedule and per-cycle compare
module tb_clause_db_ctrl;
  logic       clk = 1'b0, rst = 1'b0;
  logic       ld_req = 1'b0, lk_req = 1'b0, scan_start = 1'b0;
  logic [2:0] ld_addr = '0, lk_addr = '0;
  logic [6:0] ld_data = '0, scan_mask = '0;
  logic       ld_ack, lk_ack, lk_valid, scan_busy, scan_done, db_en, db_write;
  logic [6:0] lk_data, scan_result, db_in, db_out;
  logic [2:0] db_address;
  int checks = 0, errors = 0;

  localparam logic [6:0] INIT [8] = '{7'b0010001, 7'b0000011, 7'b0100100, 7'b0001100,
                                     7'b1000000, 7'b1101000, 7'b0110000, 7'b0000000};

  clause_db_ctrl dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_ack(lk_ack), .lk_valid(lk_valid), .lk_data(lk_data),
    .scan_start(scan_start), .scan_mask(scan_mask), .scan_busy(scan_busy), .scan_done(scan_done),
    .scan_result(scan_result),
    .db_en(db_en), .db_write(db_write), .db_address(db_address), .db_in(db_in), .db_out(db_out)
  );

  always #5 clk = ~clk;

  // database: registered read, output zero whenever no read was issued
  logic [6:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = INIT[i];
  always @(posedge clk) begin
    if (db_en && db_write) mem[db_address] <= db_in;
    db_out <= (db_en && !db_write) ? mem[db_address] : 7'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  // reference: on each accepted request, schedule what every output must show in the following cycles
  typedef struct packed {
    logic ld_ack, lk_ack, lk_valid, busy, done, en, wr;
    logic [2:0] addr;
    logic [6:0] din;
  } exp_t;
  exp_t       expq [4096];
  logic       lset [4096], rset [4096];
  logic [6:0] lval [4096], rval [4096];
  logic [6:0] ref_mem [8];
  int cyc = 0, free_at = 0;
  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = INIT[i];
    for (int i = 0; i < 4096; i++) begin
      expq[i] = '0; lset[i] = 1'b0; rset[i] = 1'b0; lval[i] = '0; rval[i] = '0;
    end
  end
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      for (int c = cyc; c < cyc + 20; c++) begin
        expq[c] = '0; lset[c] = 1'b0; rset[c] = 1'b0;
      end
      free_at = cyc;
    end else if (cyc >= free_at) begin
      if (ld_req) begin
        expq[cyc].ld_ack = 1'b1;
        if (ld_addr < 3'd7) begin
          expq[cyc].en = 1'b1; expq[cyc].wr = 1'b1;
          expq[cyc].addr = ld_addr; expq[cyc].din = ld_data;
          ref_mem[ld_addr] = ld_data;
        end
        free_at = cyc + 2;
      end else if (scan_start) begin
        logic [6:0] r;
        r = '0;
        for (int k = 0; k < 7; k++) if (scan_mask[k]) r |= ref_mem[k];
        for (int k = 0; k < 8; k++) expq[cyc+k].busy = 1'b1;
        for (int k = 0; k < 7; k++) begin
          expq[cyc+k].en = 1'b1; expq[cyc+k].addr = 3'(k);
        end
        expq[cyc+8].done = 1'b1; rset[cyc+8] = 1'b1; rval[cyc+8] = r;
        free_at = cyc + 9;
      end else if (lk_req) begin
        expq[cyc].lk_ack = 1'b1;
        if (lk_addr < 3'd7) begin
          expq[cyc].en = 1'b1; expq[cyc].addr = lk_addr;
        end
        expq[cyc+2].lk_valid = 1'b1; lset[cyc+2] = 1'b1;
        lval[cyc+2] = lk_addr < 3'd7 ? ref_mem[lk_addr] : 7'b0;
        free_at = cyc + 4;
      end
    end
  end

  logic [6:0] cur_l = '0, cur_r = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      cur_l = '0; cur_r = '0;
      chk("reset_outputs", 32'({ld_ack, lk_ack, lk_valid, scan_busy, scan_done, db_en, db_write,
                                db_address, db_in, lk_data, scan_result}), 32'd0);
    end else begin
      if (lset[cyc]) cur_l = lval[cyc];
      if (rset[cyc]) cur_r = rval[cyc];
      e = expq[cyc];
      chk("ld_ack", 32'(ld_ack), 32'(e.ld_ack));
      chk("lk_ack", 32'(lk_ack), 32'(e.lk_ack));
      chk("lk_valid", 32'(lk_valid), 32'(e.lk_valid));
      chk("lk_data", 32'(lk_data), 32'(cur_l));
      chk("scan_busy", 32'(scan_busy), 32'(e.busy));
      chk("scan_done", 32'(scan_done), 32'(e.done));
      chk("scan_result", 32'(scan_result), 32'(cur_r));
      chk("db_en", 32'(db_en), 32'(e.en));
      chk("db_write", 32'(db_write), 32'(e.wr));
      chk("db_address", 32'(db_address), 32'(e.addr));
      chk("db_in", 32'(db_in), 32'(e.din));
    end
  end

  task automatic do_lookup(input logic [2:0] a, input logic [6:0] d);
    int k;
    logic en;
    @(negedge clk); #1 lk_req = 1'b1; lk_addr = a;
    k = 0; en = 1'b0;
    do begin @(negedge clk); k++; en |= db_en; end while (!lk_ack && k < 50);
    chk("t_lk_ack_seen", 32'(lk_ack), 32'd1);
    #1 lk_req = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; en |= db_en; end while (!lk_valid && k < 10);
    chk("t_lk_latency", 32'(k), 32'd2);
    chk("t_lk_data", 32'(lk_data), 32'(d));
    chk("t_lk_db_en", 32'(en), 32'(a < 3'd7));
  endtask

  task automatic do_load(input logic [2:0] a, input logic [6:0] d);
    int k;
    @(negedge clk); #1 ld_req = 1'b1; ld_addr = a; ld_data = d;
    k = 0;
    do begin @(negedge clk); k++; end while (!ld_ack && k < 50);
    chk("t_ld_ack_seen", 32'(ld_ack), 32'd1);
    chk("t_ld_db_en", 32'(db_en), 32'(a < 3'd7));
    chk("t_ld_db_write", 32'(db_write), 32'(a < 3'd7));
    #1 ld_req = 1'b0;
    @(negedge clk);
    chk("t_ld_write_pulse", 32'(db_write), 32'd0);
  endtask

  task automatic do_scan(input logic [6:0] m, input logic [6:0] r);
    int k;
    @(negedge clk); #1 scan_start = 1'b1; scan_mask = m;
    @(negedge clk);
    chk("t_scan_busy_start", 32'(scan_busy), 32'd1);
    #1 scan_start = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!scan_done && k < 30);
    chk("t_scan_latency", 32'(k), 32'd8);
    chk("t_scan_result", 32'(scan_result), 32'(r));
    chk("t_scan_busy_done", 32'(scan_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    do_lookup(3'd3, 7'b0001100);
    do_load(3'd4, 7'b1010101);
    do_lookup(3'd4, 7'b1010101);
    do_load(3'd7, 7'b1111111);
    // loader and lookup together: loader first, lookup two cycles later
    @(negedge clk); #1 ld_req = 1'b1; ld_addr = 3'd2; ld_data = 7'b0110110; lk_req = 1'b1; lk_addr = 3'd2;
    t = 0;
    do begin @(negedge clk); t++; end while (!ld_ack && t < 20);
    chk("t_both_ld_ack", 32'(ld_ack), 32'd1);
    chk("t_both_no_lk_ack", 32'(lk_ack), 32'd0);
    #1 ld_req = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!lk_ack && t < 20);
    chk("t_lk_after_ld", 32'(t), 32'd2);
    #1 lk_req = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!lk_valid && t < 10);
    chk("t_lk_after_ld_data", 32'(lk_data), 32'(7'b0110110));
    do_scan(7'b0000011, 7'b0010011);
    do_scan(7'b1100000, 7'b1111000);
    do_scan(7'b0000000, 7'b0000000);
    // lookup and a second start during a scan
    @(negedge clk); #1 scan_start = 1'b1; scan_mask = 7'b0000011;
    @(negedge clk); #1 scan_start = 1'b0; lk_req = 1'b1; lk_addr = 3'd5;
    @(negedge clk); #1 scan_start = 1'b1; scan_mask = 7'b1111111;
    @(negedge clk); #1 scan_start = 1'b0;
    t = 2;
    do begin @(negedge clk); t++; end while (!lk_ack && t < 40);
    chk("t_lk_wait_scan", 32'(t), 32'd9);
    chk("t_scan_ignore_restart", 32'(scan_result), 32'(7'b0010011));
    #1 lk_req = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!lk_valid && t < 10);
    chk("t_lk_after_scan_data", 32'(lk_data), 32'(7'b1101000));
    // reset in the fourth scan cycle
    @(negedge clk); #1 scan_start = 1'b1; scan_mask = 7'b1100000;
    @(negedge clk); #1 scan_start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("t_async_reset", 32'({ld_ack, lk_ack, lk_valid, scan_busy, scan_done, db_en, db_write,
                                 db_address, db_in, lk_data, scan_result}), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    do_scan(7'b0000011, 7'b0010011);
    do_lookup(3'd7, 7'b0000000);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
